// File: rtl/outport_ctrl_n_pkg.sv
// Shared router definitions: output-port FSM encoding and packed dst-bus width helpers.
package outport_ctrl_n_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } oc_state_t;

    // Width of a packed per-input destination bus (input i at [i*portw +: portw]).
    function automatic int dst_bus_w(input int nport, input int portw);
        return nport * portw;
    endfunction

    // Width of an index into nport inputs; never zero so single-port builds still elaborate.
    function automatic int ptr_w(input int nport);
        return (nport > 1) ? $clog2(nport) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_n.sv
// Round-robin arbiter: grants the first set request at or after ptr, wrapping to index 0.
// Purely combinational; one-hot or zero output.
module rr_arb_n
    import outport_ctrl_n_pkg::*;
#(
    parameter int NPORT = 5
) (
    input  logic [NPORT-1:0]          req,
    input  logic [ptr_w(NPORT)-1:0]   ptr,
    output logic [NPORT-1:0]          grt
);

    int   idx;
    logic found;

    always_comb begin
        grt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NPORT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NPORT) begin
                idx = idx - NPORT;
            end
            if (!found && req[idx]) begin
                grt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/outport_ctrl_n.sv
// Per-output-port crossbar controller: two-class round-robin arbitration, packet locking
// head-to-tail, downstream credit tracking and a registered crossbar select.
module outport_ctrl_n
    import outport_ctrl_n_pkg::*;
#(
    parameter int NPORT   = 5,
    parameter int PORTW   = 3,
    parameter int PORTID  = 0,
    parameter int CREDITS = 4,
    parameter int CNTW    = 3
) (
    input  logic                              clk,
    input  logic                              rst_,
    input  logic [NPORT-1:0]                  req,
    input  logic [dst_bus_w(NPORT,PORTW)-1:0] dst,
    input  logic [NPORT-1:0]                  tail,
    input  logic [NPORT-1:0]                  prio,
    input  logic                              credit_in,
    output logic [NPORT-1:0]                  grt,
    output logic [NPORT-1:0]                  sel,
    output logic                              busy,
    output logic [CNTW-1:0]                   credit_cnt,
    output logic                              ovf_err
);

    localparam int PTRW = ptr_w(NPORT);

    oc_state_t        state_q;
    logic [PTRW-1:0]  owner_q;
    logic [PTRW-1:0]  ptr_q;
    logic [NPORT-1:0] sel_q;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [NPORT-1:0] match;
    logic [NPORT-1:0] hmask;
    logic [NPORT-1:0] cand;
    logic [NPORT-1:0] arb_grt;
    logic [NPORT-1:0] owner_oh;
    logic [PTRW-1:0]  win_idx;
    logic [PTRW-1:0]  next_ptr;
    logic             ok;
    logic             xfer;
    logic             tail_win;

    always_comb begin
        match = '0;
        for (int i = 0; i < NPORT; i++) begin
            match[i] = req[i] && (dst[i*PORTW +: PORTW] == PORTW'(PORTID));
        end
    end

    assign ok    = (cnt_q != '0);
    assign hmask = match & prio;
    assign cand  = (|hmask) ? hmask : match;

    rr_arb_n #(
        .NPORT (NPORT)
    ) u_arb (
        .req (cand),
        .ptr (ptr_q),
        .grt (arb_grt)
    );

    assign owner_oh = NPORT'(1) << owner_q;

    // While locked, only the owner may move, regardless of other inputs' class.
    always_comb begin
        grt = '0;
        if (!rst_ && ok) begin
            if (state_q == IDLE) begin
                grt = arb_grt;
            end else if (match[owner_q]) begin
                grt = owner_oh;
            end
        end
    end

    assign xfer     = |grt;
    assign tail_win = |(grt & tail);

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grt[i]) begin
                win_idx = PTRW'(i);
            end
        end
    end

    assign next_ptr = (win_idx == PTRW'(NPORT-1)) ? '0 : win_idx + PTRW'(1);

    // A returned credit with nothing consumed at full count saturates and flags overflow.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (xfer && !credit_in) begin
            cnt_d = cnt_q - CNTW'(1);
        end else if (credit_in && !xfer) begin
            if (cnt_q == CNTW'(CREDITS)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= CNTW'(CREDITS);
            ovf_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (xfer) begin
                sel_q <= grt;
            end
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        if (tail_win) begin
                            ptr_q <= next_ptr;
                        end else begin
                            state_q <= LOCKED;
                            owner_q <= win_idx;
                        end
                    end
                end
                LOCKED: begin
                    if (xfer && tail_win) begin
                        state_q <= IDLE;
                        ptr_q   <= next_ptr;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel        = sel_q;
    assign busy       = (state_q == LOCKED);
    assign credit_cnt = cnt_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_outport_ctrl_n.sv
// Directed bench for outport_ctrl_n with NPORT=5, PORTID=2, CREDITS=4.
module tb_outport_ctrl_n;

    localparam logic [14:0] D2   = 15'b010_010_010_010_010;
    localparam logic [14:0] D_X1 = 15'b010_010_010_001_010;

    logic        clk;
    logic        rst_;
    logic [4:0]  req;
    logic [14:0] dst;
    logic [4:0]  tail;
    logic [4:0]  prio;
    logic        credit_in;
    logic [4:0]  grt;
    logic [4:0]  sel;
    logic        busy;
    logic [2:0]  credit_cnt;
    logic        ovf_err;

    int n_chk  = 0;
    int n_fail = 0;

    outport_ctrl_n #(
        .NPORT   (5),
        .PORTW   (3),
        .PORTID  (2),
        .CREDITS (4),
        .CNTW    (3)
    ) dut (
        .clk        (clk),
        .rst_       (rst_),
        .req        (req),
        .dst        (dst),
        .tail       (tail),
        .prio       (prio),
        .credit_in  (credit_in),
        .grt        (grt),
        .sel        (sel),
        .busy       (busy),
        .credit_cnt (credit_cnt),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  req;
        logic [14:0] dst;
        logic [4:0]  tail;
        logic [4:0]  prio;
        logic        cin;
        logic [4:0]  e_grt;
        logic [4:0]  e_sel;
        logic        e_busy;
        logic [2:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rq, input logic [14:0] d,
                         input logic [4:0] t, input logic [4:0] p, input logic c);
        rst_      = r;
        req       = rq;
        dst       = d;
        tail      = t;
        prio      = p;
        credit_in = c;
    endtask

    // Inputs change 1 unit after a rising edge; grt is sampled 1 unit later.
    task automatic cyc(input string name, input logic r, input logic [4:0] rq,
                       input logic [4:0] t, input logic [4:0] p, input logic c,
                       input logic [4:0] e_grt, input logic e_busy);
        drive(r, rq, D2, t, p, c);
        #1;
        chk({name, " grt"}, 32'(grt), 32'(e_grt));
        @(posedge clk);
        #1;
        chk({name, " busy"}, 32'(busy), 32'(e_busy));
    endtask

    task automatic do_reset();
        drive(1'b1, 5'b0, D2, 5'b0, 5'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 5'b0, D2, 5'b0, 5'b0, 1'b0);

        //             rst req       dst   tail      prio      cin  grt       sel       bsy cnt ovf
        tbl[0]  = '{1'b1, 5'b00000, D2,   5'b11111, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd4, 1'b0};
        tbl[1]  = '{1'b0, 5'b10100, D2,   5'b11111, 5'b00000, 1'b0, 5'b00100, 5'b00100, 1'b0, 3'd3, 1'b0};
        tbl[2]  = '{1'b0, 5'b10100, D2,   5'b11111, 5'b00000, 1'b0, 5'b10000, 5'b10000, 1'b0, 3'd2, 1'b0};
        tbl[3]  = '{1'b0, 5'b11111, D2,   5'b11111, 5'b01000, 1'b1, 5'b01000, 5'b01000, 1'b0, 3'd2, 1'b0};
        tbl[4]  = '{1'b0, 5'b11111, D2,   5'b11111, 5'b00000, 1'b0, 5'b10000, 5'b10000, 1'b0, 3'd1, 1'b0};
        tbl[5]  = '{1'b0, 5'b00010, D_X1, 5'b11111, 5'b00000, 1'b0, 5'b00000, 5'b10000, 1'b0, 3'd1, 1'b0};
        tbl[6]  = '{1'b0, 5'b00001, D2,   5'b11111, 5'b00000, 1'b0, 5'b00001, 5'b00001, 1'b0, 3'd0, 1'b0};
        tbl[7]  = '{1'b0, 5'b00010, D2,   5'b11111, 5'b00000, 1'b0, 5'b00000, 5'b00001, 1'b0, 3'd0, 1'b0};
        tbl[8]  = '{1'b0, 5'b00010, D2,   5'b11111, 5'b00000, 1'b1, 5'b00000, 5'b00001, 1'b0, 3'd1, 1'b0};
        tbl[9]  = '{1'b0, 5'b00010, D2,   5'b11111, 5'b00000, 1'b0, 5'b00010, 5'b00010, 1'b0, 3'd0, 1'b0};
        tbl[10] = '{1'b0, 5'b00000, D2,   5'b11111, 5'b00000, 1'b1, 5'b00000, 5'b00010, 1'b0, 3'd1, 1'b0};
        tbl[11] = '{1'b0, 5'b00000, D2,   5'b11111, 5'b00000, 1'b1, 5'b00000, 5'b00010, 1'b0, 3'd2, 1'b0};
        tbl[12] = '{1'b0, 5'b00000, D2,   5'b11111, 5'b00000, 1'b1, 5'b00000, 5'b00010, 1'b0, 3'd3, 1'b0};
        tbl[13] = '{1'b0, 5'b00000, D2,   5'b11111, 5'b00000, 1'b1, 5'b00000, 5'b00010, 1'b0, 3'd4, 1'b0};
        tbl[14] = '{1'b0, 5'b00000, D2,   5'b11111, 5'b00000, 1'b1, 5'b00000, 5'b00010, 1'b0, 3'd4, 1'b1};
        tbl[15] = '{1'b0, 5'b00000, D2,   5'b11111, 5'b00000, 1'b0, 5'b00000, 5'b00010, 1'b0, 3'd4, 1'b1};

        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].dst, tbl[i].tail, tbl[i].prio, tbl[i].cin);
            #1;
            chk($sformatf("v%0d grt", i), 32'(grt), 32'(tbl[i].e_grt));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d sel", i), 32'(sel), 32'(tbl[i].e_sel));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d cnt", i), 32'(credit_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d ovf", i), 32'(ovf_err), 32'(tbl[i].e_ovf));
        end

        // Packet lock: input 1 sends 3 flits with a bubble, input 3 waits.
        do_reset();
        cyc("lock f1",     1'b0, 5'b01010, 5'b00000, 5'b00000, 1'b0, 5'b00010, 1'b1);
        cyc("lock bubble", 1'b0, 5'b01000, 5'b00000, 5'b01000, 1'b0, 5'b00000, 1'b1);
        cyc("lock f2",     1'b0, 5'b01010, 5'b00000, 5'b01000, 1'b0, 5'b00010, 1'b1);
        cyc("lock f3",     1'b0, 5'b01010, 5'b00010, 5'b00000, 1'b0, 5'b00010, 1'b0);
        chk("lock sel", 32'(sel), 32'(5'b00010));
        cyc("lock next",   1'b0, 5'b01000, 5'b01000, 5'b00000, 1'b0, 5'b01000, 1'b0);
        chk("lock cnt", 32'(credit_cnt), 32'd0);

        // Credit exhaustion then one returned credit.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("cred p%0d", i), 1'b0, 5'b00001, 5'b11111, 5'b00000, 1'b0,
                (i < 4) ? 5'b00001 : 5'b00000, 1'b0);
            chk($sformatf("cred p%0d cnt", i), 32'(credit_cnt), (i < 4) ? 32'(3 - i) : 32'd0);
        end
        cyc("cred ret", 1'b0, 5'b00001, 5'b11111, 5'b00000, 1'b1, 5'b00000, 1'b0);
        chk("cred ret cnt", 32'(credit_cnt), 32'd1);
        cyc("cred after", 1'b0, 5'b00001, 5'b11111, 5'b00000, 1'b0, 5'b00001, 1'b0);
        chk("cred after cnt", 32'(credit_cnt), 32'd0);

        // Reset while locked on input 0, then input 4 granted at once.
        do_reset();
        cyc("rst lock", 1'b0, 5'b00001, 5'b00000, 5'b00000, 1'b0, 5'b00001, 1'b1);
        cyc("rst mid",  1'b1, 5'b00001, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0);
        chk("rst sel", 32'(sel), 32'd0);
        chk("rst cnt", 32'(credit_cnt), 32'd4);
        cyc("rst new",  1'b0, 5'b10000, 5'b10000, 5'b00000, 1'b0, 5'b10000, 1'b0);
        chk("rst new sel", 32'(sel), 32'(5'b10000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
